// File: rtl/toggle_cover_collector.sv
// Toggle-coverage producer: detects bus bit toggles, keeps a sticky covered bitmap and streams
// each newly covered point's global index once over valid/ready. Define TOGGLE_FALL_EN to add fall points.
module toggle_cover_collector #(
    parameter int unsigned     WIDTH       = 27,
    parameter longint unsigned COVER_INDEX = 0,
    parameter int unsigned     IDX_W       = 64,
`ifdef TOGGLE_FALL_EN
    localparam int unsigned    NPTS        = 2 * WIDTH
`else
    localparam int unsigned    NPTS        = WIDTH
`endif
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] sig,
    output logic             hit_valid,
    input  logic             hit_ready,
    output logic [IDX_W-1:0] hit_index,
    output logic [NPTS-1:0]  covered,
    output logic             done
);

    logic [WIDTH-1:0] sig_q;
    logic             primed_q;
    logic [NPTS-1:0]  covered_q, covered_d;
    logic [NPTS-1:0]  pending_q, pending_d;
    logic             hit_valid_q, hit_valid_d;
    logic [IDX_W-1:0] hit_index_q, hit_index_d;
    logic             done_q;

    logic [WIDTH-1:0] arm_vec;
    logic [NPTS-1:0]  hit_pts;
    logic [NPTS-1:0]  new_pts;
    logic [NPTS-1:0]  sel_oh;
    logic [IDX_W-1:0] sel_num;
    logic             load;

    assign arm_vec = {WIDTH{primed_q & enable}};

`ifdef TOGGLE_FALL_EN
    assign hit_pts = {arm_vec & sig_q & ~sig, arm_vec & ~sig_q & sig};
`else
    assign hit_pts = arm_vec & ~sig_q & sig;
`endif

    // Only first hits are recorded; a covered point can never re-enter pending.
    assign new_pts = hit_pts & ~covered_q;
    assign load    = (|pending_q) && (!hit_valid_q || hit_ready);

    // Isolate the lowest pending bit so emission is in ascending point order.
    assign sel_oh  = pending_q & (~pending_q + NPTS'(1));

    always_comb begin
        sel_num = '0;
        for (int p = int'(NPTS) - 1; p >= 0; p--) begin
            if (pending_q[p]) begin
                sel_num = IDX_W'(p);
            end
        end
    end

    always_comb begin
        covered_d   = covered_q | new_pts;
        pending_d   = pending_q | new_pts;
        hit_valid_d = hit_valid_q;
        hit_index_d = hit_index_q;
        if (load) begin
            pending_d   = (pending_q & ~sel_oh) | new_pts;
            hit_valid_d = 1'b1;
            hit_index_d = IDX_W'(COVER_INDEX) + sel_num;
        end else if (hit_valid_q && hit_ready) begin
            hit_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sig_q       <= '0;
            primed_q    <= 1'b0;
            covered_q   <= '0;
            pending_q   <= '0;
            hit_valid_q <= 1'b0;
            hit_index_q <= '0;
            done_q      <= 1'b0;
        end else begin
            sig_q       <= sig;
            primed_q    <= 1'b1;
            covered_q   <= covered_d;
            pending_q   <= pending_d;
            hit_valid_q <= hit_valid_d;
            hit_index_q <= hit_index_d;
            done_q      <= &covered_q;
        end
    end

    assign hit_valid = hit_valid_q;
    assign hit_index = hit_index_q;
    assign covered   = covered_q;
    assign done      = done_q;

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Randomized and directed bench for toggle_cover_collector against a per-cycle behavioural model.
module tb_toggle_cover_collector;

    localparam int unsigned     WIDTH = 27;
    localparam int unsigned     IDX_W = 64;
    localparam longint unsigned CI    = 64'h0000_0001_0000_0100;
`ifdef TOGGLE_FALL_EN
    localparam int unsigned     NPTS  = 2 * WIDTH;
`else
    localparam int unsigned     NPTS  = WIDTH;
`endif

    logic             clock;
    logic             reset_n;
    logic             enable;
    logic [WIDTH-1:0] sig;
    logic             hit_valid;
    logic             hit_ready;
    logic [IDX_W-1:0] hit_index;
    logic [NPTS-1:0]  covered;
    logic             done;

    toggle_cover_collector #(
        .WIDTH       (WIDTH),
        .COVER_INDEX (CI),
        .IDX_W       (IDX_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .sig       (sig),
        .hit_valid (hit_valid),
        .hit_ready (hit_ready),
        .hit_index (hit_index),
        .covered   (covered),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [WIDTH-1:0] m_sigq;
    logic             m_primed;
    logic [NPTS-1:0]  m_cov;
    logic [NPTS-1:0]  m_pend;
    logic             m_valid;
    logic [IDX_W-1:0] m_idx;
    logic             m_done;
    logic [IDX_W-1:0] acc[$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sigq   = '0;
        m_primed = 1'b0;
        m_cov    = '0;
        m_pend   = '0;
        m_valid  = 1'b0;
        m_idx    = '0;
        m_done   = 1'b0;
        acc.delete();
    endtask

    task automatic compare(input string tag);
        check_eq({tag, ".valid"}, 128'(hit_valid), 128'(m_valid));
        if (m_valid) check_eq({tag, ".index"}, 128'(hit_index), 128'(m_idx));
        check_eq({tag, ".covered"}, 128'(covered), 128'(m_cov));
        check_eq({tag, ".done"}, 128'(done), 128'(m_done));
    endtask

    // One clock: model next state from current inputs, take the edge, compare #1 later.
    task automatic step();
        logic [NPTS-1:0]  n_cov, n_pend;
        logic             n_valid;
        logic [IDX_W-1:0] n_idx;
        bool_loaded: begin end
        n_cov   = m_cov;
        n_pend  = m_pend;
        n_valid = m_valid;
        n_idx   = m_idx;
        if (hit_valid && hit_ready) acc.push_back(hit_index);
        if (m_pend != 0 && (!m_valid || hit_ready)) begin
            for (int p = 0; p < int'(NPTS); p++) begin
                if (m_pend[p]) begin
                    n_idx     = CI + longint'(p);
                    n_pend[p] = 1'b0;
                    n_valid   = 1'b1;
                    break;
                end
            end
        end else if (m_valid && hit_ready) begin
            n_valid = 1'b0;
        end
        if (m_primed && enable) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (!m_sigq[i] && sig[i] && !m_cov[i]) begin
                    n_cov[i]  = 1'b1;
                    n_pend[i] = 1'b1;
                end
`ifdef TOGGLE_FALL_EN
                if (m_sigq[i] && !sig[i] && !m_cov[WIDTH+i]) begin
                    n_cov[WIDTH+i]  = 1'b1;
                    n_pend[WIDTH+i] = 1'b1;
                end
`endif
            end
        end
        @(posedge clock);
        #1;
        m_done   = (m_cov == {NPTS{1'b1}});
        m_cov    = n_cov;
        m_pend   = n_pend;
        m_valid  = n_valid;
        m_idx    = n_idx;
        m_sigq   = sig;
        m_primed = 1'b1;
        compare("cyc");
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        compare("reset");
        check_eq("reset.valid_zero", 128'(hit_valid), 128'(0));
        check_eq("reset.covered_zero", 128'(covered), 128'(0));
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] mask;
        reset_n   = 1'b0;
        enable    = 1'b1;
        hit_ready = 1'b1;
        sig       = '0;

        // T1: single rise of bit 3, later toggles ignored
        do_reset();
        step();
        sig[3] = 1'b1;
        repeat (4) step();
        check_eq("t1.count", 128'(acc.size()), 128'(1));
        if (acc.size() > 0) check_eq("t1.index", 128'(acc[0]), 128'(CI + 3));
        check_eq("t1.covered", 128'(covered), 128'(1) << 3);
        for (int k = 0; k < 4; k++) begin
            sig[3] = ~sig[3];
            step();
        end
        repeat (3) step();
        check_eq("t1.no_reemit", 128'(acc.size()), 128'(1));

        // T2: all ones during the prime cycle is capture-only
        sig = '0;
        do_reset();
        sig = '1;
        repeat (4) step();
        check_eq("t2.covered", 128'(covered), 128'(0));
        check_eq("t2.count", 128'(acc.size()), 128'(0));

        // T3: three simultaneous rises under backpressure
        sig = '0;
        do_reset();
        step();
        hit_ready = 1'b0;
        sig = WIDTH'(1) | (WIDTH'(1) << 5) | (WIDTH'(1) << 26);
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            check_eq("t3.stall_valid", 128'(hit_valid), 128'(1));
            check_eq("t3.stall_index", 128'(hit_index), 128'(CI));
            if (k < 3) step();
        end
        hit_ready = 1'b1;
        repeat (4) step();
        check_eq("t3.count", 128'(acc.size()), 128'(3));
        if (acc.size() == 3) begin
            check_eq("t3.i0", 128'(acc[0]), 128'(CI));
            check_eq("t3.i1", 128'(acc[1]), 128'(CI + 5));
            check_eq("t3.i2", 128'(acc[2]), 128'(CI + 26));
        end
        check_eq("t3.done", 128'(done), 128'(0));

        // T4: disabled toggles are not recorded
        sig = '0;
        do_reset();
        enable = 1'b0;
        step();
        sig[7] = 1'b1;
        repeat (3) step();
        check_eq("t4.dis_count", 128'(acc.size()), 128'(0));
        check_eq("t4.dis_covered", 128'(covered), 128'(0));
        enable = 1'b1;
        sig[7] = 1'b0;
        step();
        sig[7] = 1'b1;
        repeat (3) step();
        check_eq("t4.count", 128'(acc.size()), 128'(1));
        if (acc.size() > 0) check_eq("t4.index", 128'(acc[0]), 128'(CI + 7));

        // T5: all bits rise, full drain in ascending order
        sig = '0;
        do_reset();
        step();
        sig = '1;
        repeat (WIDTH + 4) step();
        check_eq("t5.count", 128'(acc.size()), 128'(WIDTH));
        for (int k = 0; k < acc.size(); k++) check_eq("t5.order", 128'(acc[k]), 128'(CI + k));
`ifndef TOGGLE_FALL_EN
        check_eq("t5.done", 128'(done), 128'(1));
`endif
        // Reset in the middle of a drain
        sig = '0;
        do_reset();
        step();
        sig = '1;
        repeat (5) step();
        check_eq("t5.mid_valid", 128'(hit_valid), 128'(1));
        do_reset();

`ifdef TOGGLE_FALL_EN
        // T6: fall point and done needing both edges
        sig = WIDTH'(1) << 2;
        do_reset();
        step();
        sig = '0;
        repeat (3) step();
        check_eq("t6.count", 128'(acc.size()), 128'(1));
        if (acc.size() > 0) check_eq("t6.index", 128'(acc[0]), 128'(CI + WIDTH + 2));
        sig = '1;
        repeat (WIDTH + 3) step();
        check_eq("t6.not_done", 128'(done), 128'(0));
        sig = '0;
        repeat (WIDTH + 3) step();
        check_eq("t6.done", 128'(done), 128'(1));
`endif

        // Randomized phase
        sig = '0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            mask      = WIDTH'($urandom & $urandom & $urandom & $urandom);
            sig       = sig ^ mask;
            enable    = ($urandom_range(0, 3) != 0);
            hit_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        enable    = 1'b1;
        hit_ready = 1'b1;
        sig       = '0;
        step();
        sig = '1;
        step();
        sig = '0;
        repeat (2 * NPTS + 5) step();
        check_eq("rand.done", 128'(done), 128'(1));
        check_eq("rand.count", 128'(acc.size()), 128'(NPTS));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
